// File: rtl/lenet_pkg.sv
// lenet_pkg: datapath widths, kernel size and accumulator bounds shared by the LeNet conv stages
package lenet_pkg;
  localparam int DATA_W      = 8;
  localparam int ACC_W       = 21;
  localparam int GUARD_W     = 4;
  localparam int KERNEL_TAPS = 25;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_mac_sat.sv
// conv_mac_sat: narrows the guarded accumulator to the output width; clamps when CONV_MAC_SAT_EN is defined, wraps otherwise
module conv_mac_sat import lenet_pkg::*; #(
  parameter int OUT_W = ACC_W,
  parameter int IN_W  = ACC_W + GUARD_W
) (
  input  logic signed [IN_W-1:0]  i_acc,
  output logic signed [OUT_W-1:0] o_res
);
`ifdef CONV_MAC_SAT_EN
  logic w_fits;
  // value fits when every bit above the output sign bit matches it; otherwise pick the rail by the true sign
  always_comb begin
    w_fits = (i_acc[IN_W-1:OUT_W-1] == '0) || (i_acc[IN_W-1:OUT_W-1] == '1);
    o_res  = w_fits ? i_acc[OUT_W-1:0]
                    : (i_acc[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
  end
`else
  logic w_unused;
  assign w_unused = ^i_acc[IN_W-1:OUT_W];
  assign o_res    = i_acc[OUT_W-1:0];
`endif
endmodule

// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator: windowed signed MAC (TAPS products + bias) with optional output clamp under CONV_MAC_SAT_EN
module conv_mac_accumulator import lenet_pkg::*; #(
  parameter int TAPS    = KERNEL_TAPS,
  parameter int DATA_W  = lenet_pkg::DATA_W,
  parameter int ACC_W   = lenet_pkg::ACC_W,
  parameter int GUARD_W = lenet_pkg::GUARD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_pixel,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic signed [ACC_W-1:0]  in_bias,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     busy
);
  localparam int CNT_W = cnt_w(TAPS);
  localparam int AW    = ACC_W + GUARD_W;
  localparam int PW    = 2 * DATA_W;

  logic [CNT_W-1:0]         r_tap_cnt;
  logic signed [PW-1:0]     r_prod;
  logic signed [ACC_W-1:0]  r_bias;
  logic                     r_p_vld;
  logic                     r_p_first;
  logic                     r_p_last;
  logic signed [AW-1:0]     r_acc;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_out_sum;
  logic                     w_first;
  logic                     w_last;
  logic signed [AW-1:0]     w_acc_next;
  logic signed [ACC_W-1:0]  w_res;

  // window position of the tap presented this cycle, and the running sum seeded by the bias on the first tap
  always_comb begin
    w_first    = r_tap_cnt == '0;
    w_last     = r_tap_cnt == CNT_W'(TAPS - 1);
    w_acc_next = (r_p_first ? {{GUARD_W{r_bias[ACC_W-1]}}, r_bias} : r_acc)
               + {{(AW-PW){r_prod[PW-1]}}, r_prod};
  end

  // stage 1: register product, window flags and bias; tap counter wraps on the last tap so windows can abut
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_cnt <= '0;
      r_p_vld   <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_prod    <= '0;
      r_bias    <= '0;
    end else if (clear) begin
      r_tap_cnt <= '0;
      r_p_vld   <= 1'b0;
    end else begin
      r_p_vld <= in_valid;
      if (in_valid) begin
        r_prod    <= in_pixel * in_weight;
        r_p_first <= w_first;
        r_p_last  <= w_last;
        if (w_first) r_bias <= in_bias;
        r_tap_cnt <= w_last ? '0 : r_tap_cnt + CNT_W'(1);
      end
    end
  end

  // stage 2: accumulate mid-window taps; on the last tap publish the narrowed sum and pulse out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else if (clear) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_p_vld && r_p_last;
      if (r_p_vld && r_p_last) r_out_sum <= w_res;
      else if (r_p_vld) r_acc <= w_acc_next;
    end
  end

  conv_mac_sat #(.OUT_W(ACC_W), .IN_W(AW)) u_sat (
    .i_acc (w_acc_next),
    .o_res (w_res)
  );

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign busy      = (r_tap_cnt != '0) || r_p_vld;
endmodule

// File: tb/tb_conv_mac_accumulator.sv
// tb_conv_mac_accumulator: directed checks of the windowed MAC (default 25 taps plus a 1-tap instance)
module tb_conv_mac_accumulator;
  logic clk, rst_n, clear, in_valid;
  logic signed [7:0]  in_pixel, in_weight;
  logic signed [20:0] in_bias;
  logic out_valid, busy, o1_valid, o1_busy;
  logic signed [20:0] out_sum, o1_sum;
  int n_chk = 0, n_err = 0, cyc = 0, np = 0, base;
  logic signed [20:0] psum [0:15];
  int pcyc [0:15];
  logic signed [20:0] held;
`ifdef CONV_MAC_SAT_EN
  localparam int OVF_EXP = 1048575;
`else
  localparam int OVF_EXP = -645352;
`endif

  conv_mac_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_weight(in_weight), .in_bias(in_bias),
    .out_valid(out_valid), .out_sum(out_sum), .busy(busy)
  );

  conv_mac_accumulator #(.TAPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_weight(in_weight), .in_bias(in_bias),
    .out_valid(o1_valid), .out_sum(o1_sum), .busy(o1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_valid && np < 16) begin
      psum[np] = out_sum;
      pcyc[np] = cyc;
      np++;
    end else if (out_valid) np++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tap(input int p, input int w, input int b);
    @(negedge clk);
    in_valid  = 1'b1;
    in_pixel  = p[7:0];
    in_weight = w[7:0];
    in_bias   = b[20:0];
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic win(input int n, input int p, input int w, input int b);
    for (int i = 0; i < n; i++) tap(p, w, b);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_pixel = '0; in_weight = '0; in_bias = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    // single window with two-cycle latency
    base = np;
    win(25, 3, 2, 10);
    idle();
    chk("w1_lat_valid", out_valid, 0);
    chk("w1_lat_busy", busy, 1);
    idle();
    chk("w1_valid", out_valid, 1);
    chk("w1_sum", out_sum, 160);
    idle();
    chk("w1_pulse_end", out_valid, 0);
    chk("w1_idle_busy", busy, 0);
    chk("w1_pulses", np - base, 1);
    // back-to-back windows
    base = np;
    win(25, 127, 127, 0);
    win(25, -128, 127, -5);
    repeat (3) idle();
    chk("b2b_pulses", np - base, 2);
    chk("b2b_sum_a", psum[base], 403225);
    chk("b2b_sum_b", psum[base+1], -406405);
    chk("b2b_spacing", pcyc[base+1] - pcyc[base], 25);
    // gapped input
    base = np;
    for (int i = 0; i < 25; i++) begin
      tap(3, 2, 10);
      for (int g = 0; g < (i * 5) % 8; g++) begin
        idle();
        if (i == 10 && g == 0) chk("gap_busy", busy, 1);
      end
    end
    repeat (3) idle();
    chk("gap_pulses", np - base, 1);
    chk("gap_sum", psum[base], 160);
    // overflow
    base = np;
    win(25, 127, 127, 1048575);
    repeat (3) idle();
    chk("ovf_pulses", np - base, 1);
    chk("ovf_sum", psum[base], OVF_EXP);
    // single-tap instance: every tap is a full window
    tap(3, 2, 10);
    tap(-4, 5, 1);
    tap(7, 7, -49);
    chk("t1_v0", o1_valid, 1);
    chk("t1_s0", o1_sum, 16);
    idle();
    chk("t1_s1", o1_sum, -19);
    idle();
    chk("t1_v2", o1_valid, 1);
    chk("t1_s2", o1_sum, 0);
    idle();
    chk("t1_end", o1_valid, 0);
    // clear mid-window, clear beats a same-cycle tap
    base = np;
    held = out_sum;
    win(12, 1, 1, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1;
    idle();
    chk("clr_busy", busy, 0);
    chk("clr_held", out_sum, OVF_EXP);
    win(25, 1, 1, 0);
    idle();
    chk("clr_hold_late", out_sum, held);
    repeat (2) idle();
    chk("clr_pulses", np - base, 1);
    chk("clr_sum", psum[base], 25);
    // asynchronous reset mid-window
    win(20, 5, 5, 100);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", out_sum, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = np;
    win(25, -2, 5, 7);
    repeat (3) idle();
    chk("arst_pulses", np - base, 1);
    chk("arst_new_sum", psum[base], -243);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
